// File: rtl/mcu_cond_pkg.sv
// Shared definitions for the conditional-execution and flag logic:
// condition codes, flag bit positions and flag-write request bits.
package mcu_cond_pkg;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    localparam int unsigned FLAGW_NZ = 1;
    localparam int unsigned FLAGW_CV = 0;

    // Merge new ALU flags into the stored set, pair-wise under the write mask.
    function automatic logic [3:0] merge_flags(
        input logic [3:0] old_flags,
        input logic [3:0] new_flags,
        input logic [1:0] flag_w
    );
        logic [3:0] res;
        res = old_flags;
        if (flag_w[FLAGW_NZ]) begin
            res[FLAG_N] = new_flags[FLAG_N];
            res[FLAG_Z] = new_flags[FLAG_Z];
        end else begin
            res[FLAG_N] = old_flags[FLAG_N];
            res[FLAG_Z] = old_flags[FLAG_Z];
        end
        if (flag_w[FLAGW_CV]) begin
            res[FLAG_C] = new_flags[FLAG_C];
            res[FLAG_V] = new_flags[FLAG_V];
        end else begin
            res[FLAG_C] = old_flags[FLAG_C];
            res[FLAG_V] = old_flags[FLAG_V];
        end
        return res;
    endfunction

endpackage

// File: rtl/cond_check.sv
// Purely combinational evaluation of a 4-bit condition code against N/Z/C/V.
module cond_check
    import mcu_cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n_s;
    logic z_s;
    logic c_s;
    logic v_s;

    assign n_s = flags[FLAG_N];
    assign z_s = flags[FLAG_Z];
    assign c_s = flags[FLAG_C];
    assign v_s = flags[FLAG_V];

    // Condition decode; code F behaves as always.
    always_comb begin
        pass = 1'b1;
        case (cond)
            COND_EQ: pass = z_s;
            COND_NE: pass = ~z_s;
            COND_CS: pass = c_s;
            COND_CC: pass = ~c_s;
            COND_MI: pass = n_s;
            COND_PL: pass = ~n_s;
            COND_VS: pass = v_s;
            COND_VC: pass = ~v_s;
            COND_HI: pass = c_s & ~z_s;
            COND_LS: pass = ~c_s | z_s;
            COND_GE: pass = (n_s == v_s);
            COND_LT: pass = (n_s != v_s);
            COND_GT: pass = ~z_s & (n_s == v_s);
            COND_LE: pass = z_s | (n_s != v_s);
            COND_AL: pass = 1'b1;
            default: pass = 1'b1;
        endcase
    end

endmodule

// File: rtl/cond_flag_unit.sv
// Architectural flag register, condition gating of write strobes and
// saturating executed/squashed instruction counters.
module cond_flag_unit
    import mcu_cond_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [3:0]       cond,
    input  logic [1:0]       flag_w,
    input  logic             reg_w,
    input  logic             mem_w,
    input  logic             pc_s,
    input  logic [3:0]       alu_flags,
    input  logic             cnt_clr,
    output logic             cond_ex,
    output logic             reg_w_o,
    output logic             mem_w_o,
    output logic             pc_s_o,
    output logic [3:0]       flags_q,
    output logic [CNT_W-1:0] exec_cnt,
    output logic [CNT_W-1:0] squash_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic             pass_s;
    logic             exec_evt_s;
    logic             squash_evt_s;
    logic [3:0]       flags_d;
    logic [CNT_W-1:0] exec_cnt_d;
    logic [CNT_W-1:0] exec_cnt_q;
    logic [CNT_W-1:0] squash_cnt_d;
    logic [CNT_W-1:0] squash_cnt_q;

    // Evaluated against the registered flags only: no same-cycle forwarding.
    cond_check u_cond_check (
        .cond  (cond),
        .flags (flags_q),
        .pass  (pass_s)
    );

    assign cond_ex      = pass_s;
    assign reg_w_o      = in_valid & reg_w & pass_s;
    assign mem_w_o      = in_valid & mem_w & pass_s;
    assign pc_s_o       = in_valid & pc_s & pass_s;
    assign exec_evt_s   = in_valid & pass_s;
    assign squash_evt_s = in_valid & ~pass_s;
    assign exec_cnt     = exec_cnt_q;
    assign squash_cnt   = squash_cnt_q;

    // Next flag value: only executed instructions may update flags.
    always_comb begin
        flags_d = flags_q;
        if (exec_evt_s) begin
            flags_d = merge_flags(flags_q, alu_flags, flag_w);
        end else begin
            flags_d = flags_q;
        end
    end

    // Next counter values: clear wins over increment, increments saturate.
    always_comb begin
        exec_cnt_d   = exec_cnt_q;
        squash_cnt_d = squash_cnt_q;
        if (cnt_clr) begin
            exec_cnt_d   = CNT_ZERO;
            squash_cnt_d = CNT_ZERO;
        end else begin
            if (exec_evt_s && (exec_cnt_q != CNT_MAX)) begin
                exec_cnt_d = exec_cnt_q + CNT_ONE;
            end else begin
                exec_cnt_d = exec_cnt_q;
            end
            if (squash_evt_s && (squash_cnt_q != CNT_MAX)) begin
                squash_cnt_d = squash_cnt_q + CNT_ONE;
            end else begin
                squash_cnt_d = squash_cnt_q;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q      <= 4'b0000;
            exec_cnt_q   <= CNT_ZERO;
            squash_cnt_q <= CNT_ZERO;
        end else begin
            flags_q      <= flags_d;
            exec_cnt_q   <= exec_cnt_d;
            squash_cnt_q <= squash_cnt_d;
        end
    end

endmodule

// File: tb/tb_cond_flag_unit.sv
// Directed self-checking bench for cond_flag_unit (counters at 4 bits so
// saturation is reachable quickly).
module tb_cond_flag_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] cond = 4'h0;
    logic [1:0] flag_w = 2'b00;
    logic       reg_w = 1'b0;
    logic       mem_w = 1'b0;
    logic       pc_s = 1'b0;
    logic [3:0] alu_flags = 4'h0;
    logic       cnt_clr = 1'b0;
    logic       cond_ex;
    logic       reg_w_o;
    logic       mem_w_o;
    logic       pc_s_o;
    logic [3:0] flags_q;
    logic [3:0] exec_cnt;
    logic [3:0] squash_cnt;

    int total = 0;
    int bad = 0;
    int exp_exec = 0;
    int exp_sq = 0;

    cond_flag_unit #(.CNT_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .cond       (cond),
        .flag_w     (flag_w),
        .reg_w      (reg_w),
        .mem_w      (mem_w),
        .pc_s       (pc_s),
        .alu_flags  (alu_flags),
        .cnt_clr    (cnt_clr),
        .cond_ex    (cond_ex),
        .reg_w_o    (reg_w_o),
        .mem_w_o    (mem_w_o),
        .pc_s_o     (pc_s_o),
        .flags_q    (flags_q),
        .exec_cnt   (exec_cnt),
        .squash_cnt (squash_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] c, input logic [1:0] fw,
                         input logic rw, input logic mw, input logic ps,
                         input logic [3:0] alu, input logic clr);
        in_valid  = v;
        cond      = c;
        flag_w    = fw;
        reg_w     = rw;
        mem_w     = mw;
        pc_s      = ps;
        alu_flags = alu;
        cnt_clr   = clr;
        #1;
    endtask

    // Reference condition table written from the architectural definitions.
    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n ~^ v;
            4'hB: return n ^ v;
            4'hC: return !z && (n ~^ v);
            4'hD: return z || (n ^ v);
            default: return 1'b1;
        endcase
    endfunction

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        total++; if (flags_q !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b exp=0000", flags_q); end
        total++; if (exec_cnt !== 4'h0) begin bad++; $display("FAIL reset_exec got=%0h exp=0", exec_cnt); end
        total++; if (squash_cnt !== 4'h0) begin bad++; $display("FAIL reset_squash got=%0h exp=0", squash_cnt); end
        drive(1'b0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
        total++; if (cond_ex !== 1'b0) begin bad++; $display("FAIL reset_eq got=%b exp=0", cond_ex); end
        drive(1'b0, 4'h1, 2'b00, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
        total++; if (cond_ex !== 1'b1) begin bad++; $display("FAIL reset_ne got=%b exp=1", cond_ex); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_cmp_branch();
        drive(1'b1, 4'hE, 2'b11, 1'b0, 1'b0, 1'b0, 4'b0110, 1'b0);
        total++; if (cond_ex !== 1'b1) begin bad++; $display("FAIL cmp_al got=%b exp=1", cond_ex); end
        tick(); exp_exec++;
        total++; if (flags_q !== 4'b0110) begin bad++; $display("FAIL cmp_flags got=%b exp=0110", flags_q); end
        drive(1'b1, 4'h0, 2'b00, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0);
        total++; if (pc_s_o !== 1'b1) begin bad++; $display("FAIL beq_taken got=%b exp=1", pc_s_o); end
        drive(1'b1, 4'h1, 2'b00, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0);
        total++; if (pc_s_o !== 1'b0) begin bad++; $display("FAIL bne_gated got=%b exp=0", pc_s_o); end
        total++; if (cond_ex !== 1'b0) begin bad++; $display("FAIL bne_cond got=%b exp=0", cond_ex); end
        tick(); exp_sq++;
        total++; if (squash_cnt !== exp_sq[3:0]) begin bad++; $display("FAIL cmp_squash got=%0d exp=%0d", squash_cnt, exp_sq); end
        total++; if (exec_cnt !== exp_exec[3:0]) begin bad++; $display("FAIL cmp_exec got=%0d exp=%0d", exec_cnt, exp_exec); end
    endtask

    task automatic test_partial();
        drive(1'b1, 4'hE, 2'b11, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b0);
        tick(); exp_exec++;
        total++; if (flags_q !== 4'b1111) begin bad++; $display("FAIL part_set got=%b exp=1111", flags_q); end
        drive(1'b1, 4'hE, 2'b10, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
        tick(); exp_exec++;
        total++; if (flags_q !== 4'b0011) begin bad++; $display("FAIL part_nz got=%b exp=0011", flags_q); end
        drive(1'b1, 4'hE, 2'b01, 1'b0, 1'b0, 1'b0, 4'b1101, 1'b0);
        tick(); exp_exec++;
        total++; if (flags_q !== 4'b0001) begin bad++; $display("FAIL part_cv got=%b exp=0001", flags_q); end
    endtask

    task automatic test_suppressed();
        drive(1'b1, 4'hE, 2'b11, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
        tick(); exp_exec++;
        drive(1'b1, 4'h0, 2'b11, 1'b1, 1'b1, 1'b0, 4'b1111, 1'b0);
        total++; if (reg_w_o !== 1'b0) begin bad++; $display("FAIL sup_reg got=%b exp=0", reg_w_o); end
        total++; if (mem_w_o !== 1'b0) begin bad++; $display("FAIL sup_mem got=%b exp=0", mem_w_o); end
        tick(); exp_sq++;
        total++; if (flags_q !== 4'b0000) begin bad++; $display("FAIL sup_flags got=%b exp=0000", flags_q); end
        total++; if (squash_cnt !== exp_sq[3:0]) begin bad++; $display("FAIL sup_squash got=%0d exp=%0d", squash_cnt, exp_sq); end
        drive(1'b0, 4'hE, 2'b00, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0);
        total++; if (cond_ex !== 1'b1) begin bad++; $display("FAIL idle_cond got=%b exp=1", cond_ex); end
        total++; if ({reg_w_o, mem_w_o, pc_s_o} !== 3'b000) begin bad++; $display("FAIL idle_strobes got=%b exp=000", {reg_w_o, mem_w_o, pc_s_o}); end
        drive(1'b1, 4'hF, 2'b00, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
        total++; if ({reg_w_o, mem_w_o} !== 2'b11) begin bad++; $display("FAIL nv_as_al got=%b exp=11", {reg_w_o, mem_w_o}); end
        tick(); exp_exec++;
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 4'hE, 2'b11, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b0);
        tick(); exp_exec++;
        drive(1'b1, 4'h0, 2'b00, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0);
        total++; if (pc_s_o !== 1'b1) begin bad++; $display("FAIL b2b_beq got=%b exp=1", pc_s_o); end
        tick(); exp_exec++;
        // NE sees stored Z=1 even though the ALU now reports Z=0.
        drive(1'b1, 4'h1, 2'b11, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
        total++; if (cond_ex !== 1'b0) begin bad++; $display("FAIL b2b_nofwd got=%b exp=0", cond_ex); end
        tick(); exp_sq++;
        total++; if (flags_q !== 4'b0100) begin bad++; $display("FAIL b2b_keep got=%b exp=0100", flags_q); end
        total++; if (exec_cnt !== exp_exec[3:0]) begin bad++; $display("FAIL b2b_exec got=%0d exp=%0d", exec_cnt, exp_exec); end
        total++; if (squash_cnt !== exp_sq[3:0]) begin bad++; $display("FAIL b2b_squash got=%0d exp=%0d", squash_cnt, exp_sq); end
    endtask

    task automatic test_conditions();
        logic [3:0] fv;
        logic [3:0] cv;
        for (int f = 0; f < 16; f++) begin
            fv = f[3:0];
            drive(1'b1, 4'hE, 2'b11, 1'b0, 1'b0, 1'b0, fv, 1'b0);
            tick();
            for (int c = 0; c < 16; c++) begin
                cv = c[3:0];
                drive(1'b0, cv, 2'b00, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
                total++;
                if (cond_ex !== ref_cond(cv, fv)) begin
                    bad++;
                    $display("FAIL cond_sweep flags=%b cond=%h got=%b exp=%b", fv, cv, cond_ex, ref_cond(cv, fv));
                end
            end
        end
        drive(1'b1, 4'hE, 2'b11, 1'b0, 1'b0, 1'b0, 4'b1001, 1'b0);
        tick();
        for (int c = 10; c < 14; c++) begin
            cv = c[3:0];
            drive(1'b0, cv, 2'b00, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
            total++;
            if (cond_ex !== ((c == 10) || (c == 12))) begin
                bad++;
                $display("FAIL signed_1001 cond=%h got=%b exp=%b", cv, cond_ex, ((c == 10) || (c == 12)));
            end
        end
    endtask

    task automatic test_counters();
        int e;
        drive(1'b0, 4'hE, 2'b00, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
        tick();
        total++; if ({exec_cnt, squash_cnt} !== 8'h00) begin bad++; $display("FAIL clr_idle got=%h exp=00", {exec_cnt, squash_cnt}); end
        for (int i = 1; i <= 20; i++) begin
            drive(1'b1, 4'hE, 2'b00, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
            tick();
            e = (i > 15) ? 15 : i;
            total++; if (exec_cnt !== e[3:0]) begin bad++; $display("FAIL exec_sat i=%0d got=%0d exp=%0d", i, exec_cnt, e); end
        end
        // Stored flags are 1001 (Z=0), so EQ fails.
        for (int i = 1; i <= 17; i++) begin
            drive(1'b1, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
            tick();
            e = (i > 15) ? 15 : i;
            total++; if (squash_cnt !== e[3:0]) begin bad++; $display("FAIL squash_sat i=%0d got=%0d exp=%0d", i, squash_cnt, e); end
        end
        total++; if (exec_cnt !== 4'hF) begin bad++; $display("FAIL exec_hold got=%0d exp=15", exec_cnt); end
        drive(1'b1, 4'hE, 2'b00, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
        tick();
        total++; if (exec_cnt !== 4'h0) begin bad++; $display("FAIL clr_prio got=%0d exp=0", exec_cnt); end
        total++; if (squash_cnt !== 4'h0) begin bad++; $display("FAIL clr_squash got=%0d exp=0", squash_cnt); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'hE, 2'b11, 1'b1, 1'b0, 1'b0, 4'hF, 1'b0);
            tick();
            total++; if ({exec_cnt, squash_cnt} !== 8'h00) begin bad++; $display("FAIL idle_cnt got=%h exp=00", {exec_cnt, squash_cnt}); end
        end
        total++; if (flags_q !== 4'b1001) begin bad++; $display("FAIL idle_flags got=%b exp=1001", flags_q); end
    endtask

    task automatic test_midstream_reset();
        drive(1'b1, 4'hE, 2'b00, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
        tick();
        total++; if (exec_cnt !== 4'h1) begin bad++; $display("FAIL mid_pre got=%0d exp=1", exec_cnt); end
        drive(1'b1, 4'hE, 2'b11, 1'b0, 1'b0, 1'b0, 4'b0110, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        total++; if (flags_q !== 4'b0000) begin bad++; $display("FAIL mid_flags got=%b exp=0000", flags_q); end
        total++; if (exec_cnt !== 4'h0) begin bad++; $display("FAIL mid_exec got=%0d exp=0", exec_cnt); end
        tick();
        total++; if (flags_q !== 4'b0000) begin bad++; $display("FAIL mid_drop got=%b exp=0000", flags_q); end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
        tick();
        total++; if (cond_ex !== 1'b0) begin bad++; $display("FAIL mid_eq got=%b exp=0", cond_ex); end
        total++; if ({exec_cnt, squash_cnt} !== 8'h00) begin bad++; $display("FAIL mid_cnt got=%h exp=00", {exec_cnt, squash_cnt}); end
    endtask

    initial begin
        test_reset();
        test_cmp_branch();
        test_partial();
        test_suppressed();
        test_back_to_back();
        test_conditions();
        test_counters();
        test_midstream_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
